// File: rtl/nf_fp_pkg.sv
// rtl/nf_fp_pkg.sv - shared small-float constants, flag layout and bias helper
package nf_fp_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 3;

    localparam logic [7:0] NAN_E4M3 = 8'h7F;
    localparam logic [7:0] MAX_E4M3 = 8'h7E;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

    typedef logic [3:0] fp_flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp8_add_lane.sv
// rtl/fp8_add_lane.sv - one adder lane with its three stage registers
module fp8_add_lane
    import nf_fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter bit SAT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic                   sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   sum,
    output fp_flags_t              flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 4;
    localparam int AW    = SW + 1;
    localparam int EW    = EXP_W + 2;
    localparam int SHMAX = MAN_W + 3;
    localparam logic [EW-1:0]    EMAX    = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     NAN_ENC = {1'b0, {(W-1){1'b1}}};
    localparam logic [MAN_W-1:0] MAX_MAN = {{(MAN_W-1){1'b1}}, 1'b0};

    logic          sb, a_nan, b_nan, a_ge_b;
    logic [W-2:0]  big_mag, small_mag;
    logic [EW-1:0] big_e, small_e, diff;
    logic [SW-1:0] big_ext, small_ext, small_al, mask;

    // Significands carry hidden bit plus three G/R/S positions below the LSB.
    always_comb begin
        sb        = b[W-1] ^ sub;
        a_nan     = &a[W-2:0];
        b_nan     = &b[W-2:0];
        a_ge_b    = a[W-2:0] >= b[W-2:0];
        big_mag   = a_ge_b ? a[W-2:0] : b[W-2:0];
        small_mag = a_ge_b ? b[W-2:0] : a[W-2:0];
        big_e     = (big_mag[W-2:MAN_W] == '0) ? EW'(1) : EW'(big_mag[W-2:MAN_W]);
        small_e   = (small_mag[W-2:MAN_W] == '0) ? EW'(1) : EW'(small_mag[W-2:MAN_W]);
        big_ext   = {|big_mag[W-2:MAN_W], big_mag[MAN_W-1:0], 3'b000};
        small_ext = {|small_mag[W-2:MAN_W], small_mag[MAN_W-1:0], 3'b000};
        diff      = big_e - small_e;
        mask      = ~({SW{1'b1}} << diff);
        if (diff >= EW'(SHMAX)) begin
            small_al = {{(SW-1){1'b0}}, |small_ext};
        end else begin
            small_al = (small_ext >> diff) | {{(SW-1){1'b0}}, |(small_ext & mask)};
        end
    end

    logic          s1_nan, s1_sign, s1_eff_sub;
    logic [EW-1:0] s1_exp;
    logic [SW-1:0] s1_big, s1_small;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_nan     <= 1'b0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_exp     <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
        end else if (adv) begin
            s1_nan     <= a_nan | b_nan;
            s1_sign    <= a_ge_b ? a[W-1] : sb;
            s1_eff_sub <= a[W-1] ^ sb;
            s1_exp     <= big_e;
            s1_big     <= big_ext;
            s1_small   <= small_al;
        end
    end

    logic [AW-1:0] add_d;
    logic [EW-1:0] lz_d;

    always_comb begin
        if (s1_eff_sub) begin
            add_d = {1'b0, s1_big} - {1'b0, s1_small};
        end else begin
            add_d = {1'b0, s1_big} + {1'b0, s1_small};
        end
        lz_d = EW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (add_d[i]) lz_d = EW'(SW - 1 - i);
        end
    end

    logic          s2_nan, s2_sign;
    logic [EW-1:0] s2_exp, s2_lz;
    logic [AW-1:0] s2_sum;

    // Exact cancellation of opposite-signed operands always yields +0.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_nan  <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_lz   <= '0;
            s2_sum  <= '0;
        end else if (adv) begin
            s2_nan  <= s1_nan;
            s2_sign <= (s1_eff_sub && add_d == '0) ? 1'b0 : s1_sign;
            s2_exp  <= s1_exp;
            s2_lz   <= lz_d;
            s2_sum  <= add_d;
        end
    end

    logic [EW-1:0]    sh, e1, e2;
    logic [SW-1:0]    norm;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] mo;
    logic             inexact, up, ovf;
    logic [W-1:0]     res;
    fp_flags_t        fl;

    // Left shift stops at exponent 1 so tiny results land as subnormals.
    always_comb begin
        if (s2_sum[AW-1]) begin
            sh   = '0;
            norm = {s2_sum[AW-1:2], s2_sum[1] | s2_sum[0]};
            e1   = s2_exp + EW'(1);
        end else begin
            sh   = (s2_lz < s2_exp) ? s2_lz : s2_exp - EW'(1);
            norm = s2_sum[SW-1:0] << sh;
            e1   = s2_exp - sh;
        end
        inexact = |norm[2:0];
        up      = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr      = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(up);
        if (mr[MAN_W+1]) begin
            e2 = e1 + EW'(1);
            mo = '0;
        end else begin
            e2 = mr[MAN_W] ? e1 : '0;
            mo = mr[MAN_W-1:0];
        end
        ovf = (e2 > EMAX) || (e2 == EMAX && &mo);
        res = {s2_sign, e2[EXP_W-1:0], mo};
        fl  = '0;
        if (s2_nan) begin
            res          = NAN_ENC;
            fl[FLAG_NV]  = 1'b1;
        end else if (ovf) begin
            res          = SAT ? {s2_sign, EMAX[EXP_W-1:0], MAX_MAN} : NAN_ENC;
            fl[FLAG_OF]  = 1'b1;
            fl[FLAG_NX]  = 1'b1;
        end else begin
            fl[FLAG_UF]  = inexact & (e2 == '0);
            fl[FLAG_NX]  = inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            flags <= '0;
        end else if (adv) begin
            sum   <= res;
            flags <= fl;
        end
    end

endmodule

// File: rtl/fp8_add_pipe.sv
// rtl/fp8_add_pipe.sv - multi-lane pipelined small-float adder with shared handshake
module fp8_add_pipe
    import nf_fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int LANES = 4,
    parameter bit SAT   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               sub,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   a,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0]   sum,
    output logic [3:0]                         flags,
    input  logic                               flags_clr
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic      v1, v2, v3, adv;
    fp_flags_t lane_fl [LANES];
    fp_flags_t beat_fl;

    // Whole pipe freezes when the output beat is held; no bubble collapsing.
    assign adv       = !v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp8_add_lane #(
            .EXP_W (EXP_W),
            .MAN_W (MAN_W),
            .SAT   (SAT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .sub   (sub),
            .a     (a[i*W +: W]),
            .b     (b[i*W +: W]),
            .sum   (sum[i*W +: W]),
            .flags (lane_fl[i])
        );
    end

    always_comb begin
        beat_fl = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_fl = beat_fl | lane_fl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= (flags_clr ? 4'b0000 : flags) | ((out_valid && out_ready) ? beat_fl : 4'b0000);
        end
    end

endmodule

// File: tb/tb_fp8_add_pipe.sv
// tb/tb_fp8_add_pipe.sv - directed table, back-pressure, reset and random checks
module tb_fp8_add_pipe;
    import nf_fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, sub, out_ready, flags_clr;
    logic [31:0] a, b;
    logic        in_ready, out_valid, ns_in_ready, ns_out_valid;
    logic [31:0] sum, ns_sum;
    logic [3:0]  flags, ns_flags;

    always #5 clk = ~clk;

    fp8_add_pipe #(.EXP_W(4), .MAN_W(3), .LANES(4), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .flags(flags), .flags_clr(flags_clr)
    );

    fp8_add_pipe #(.EXP_W(4), .MAN_W(3), .LANES(4), .SAT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready), .sub(sub),
        .a(a), .b(b), .out_valid(ns_out_valid), .out_ready(out_ready), .sum(ns_sum),
        .flags(ns_flags), .flags_clr(flags_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [31:0] q1 [$];
    logic [31:0] q0 [$];
    logic [3:0]  qf [$];
    logic [3:0]  acc;
    logic        held_valid = 1'b0;
    logic [31:0] held_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic real dec(input logic [7:0] v);
        int  e, sig, x;
        real p;
        e   = int'(v[6:3]);
        sig = (e == 0) ? int'(v[2:0]) : 8 + int'(v[2:0]);
        x   = ((e == 0) ? 1 : e) - bias(4) - 3;
        p   = 1.0;
        if (x >= 0) for (int k = 0; k < x; k++) p = p * 2.0;
        else        for (int k = 0; k < -x; k++) p = p / 2.0;
        return v[7] ? -(real'(sig) * p) : real'(sig) * p;
    endfunction

    // Exact real sum rounded to the E4M3 grid, ties to even; returns {flags, result}.
    function automatic logic [11:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic s, input bit sat);
        logic [7:0] y2, code;
        real t, ax, q, hi, n, fr, r;
        int  ni;
        logic sgn, nx;
        y2 = {y[7] ^ s, y[6:0]};
        if (x[6:0] == 7'h7F || y2[6:0] == 7'h7F) return {4'b1000, NAN_E4M3};
        t = dec(x) + dec(y2);
        if (t == 0.0) return {4'b0000, x[7] & y2[7], 7'h00};
        sgn = t < 0.0;
        ax  = sgn ? -t : t;
        q   = 1.0 / 512.0;
        hi  = 1.0 / 32.0;
        while (ax >= hi) begin
            q  = q * 2.0;
            hi = hi * 2.0;
        end
        n  = ax / q;
        ni = $rtoi(n);
        fr = n - real'(ni);
        if (fr > 0.5 || (fr == 0.5 && (ni % 2) == 1)) ni++;
        r  = real'(ni) * q;
        nx = (r != ax);
        if (r > 448.0) return {4'b0101, sat ? {sgn, MAX_E4M3[6:0]} : NAN_E4M3};
        code = 8'h00;
        for (int k = 0; k < 127; k++) if (dec(8'(k)) == r) code = 8'(k);
        return {2'b00, nx && (r < 1.0 / 64.0), nx, sgn, code[6:0]};
    endfunction

    task automatic build_exp(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                             output logic [31:0] e1, output logic [31:0] e0, output logic [3:0] ef);
        logic [11:0] r1, r0;
        ef = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            r1 = ref_add(av[i*8 +: 8], bv[i*8 +: 8], sv, 1'b1);
            r0 = ref_add(av[i*8 +: 8], bv[i*8 +: 8], sv, 1'b0);
            e1[i*8 +: 8] = r1[7:0];
            e0[i*8 +: 8] = r0[7:0];
            ef = ef | r1[11:8];
        end
    endtask

    task automatic step(input logic vin, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic ordy);
        logic [31:0] e1, e0;
        logic [3:0]  ef;
        in_valid = vin; a = av; b = bv; sub = sv; out_ready = ordy;
        @(negedge clk);
        if (out_valid) begin
            if (held_valid) chk("stall_stable", sum, held_sum);
            if (out_ready) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_output: got %h expected none", sum);
                end else begin
                    chk("out_sat", sum, q1.pop_front());
                    chk("out_nosat", ns_sum, q0.pop_front());
                    acc = acc | qf.pop_front();
                end
                n_out++;
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_sum   = sum;
            end
        end
        if (in_valid && in_ready) begin
            build_exp(a, b, sub, e1, e0, ef);
            q1.push_back(e1);
            q0.push_back(e0);
            qf.push_back(ef);
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        in_valid = 1'b0; flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        acc = 4'b0000;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] e_sat;
        logic [7:0] e_ns;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat, cyc, base_out, seen;

        tbl[0]  = '{8'h38, 8'h38, 1'b0, 8'h40, 8'h40, 4'b0000};
        tbl[1]  = '{8'h38, 8'h38, 1'b1, 8'h00, 8'h00, 4'b0000};
        tbl[2]  = '{8'h80, 8'h80, 1'b0, 8'h80, 8'h80, 4'b0000};
        tbl[3]  = '{8'h39, 8'h18, 1'b0, 8'h3A, 8'h3A, 4'b0001};
        tbl[4]  = '{8'h38, 8'h18, 1'b0, 8'h38, 8'h38, 4'b0001};
        tbl[5]  = '{8'h7E, 8'h7E, 1'b0, 8'h7E, 8'h7F, 4'b0101};
        tbl[6]  = '{8'h7F, 8'h38, 1'b0, 8'h7F, 8'h7F, 4'b1000};
        tbl[7]  = '{8'h01, 8'h01, 1'b0, 8'h02, 8'h02, 4'b0000};
        tbl[8]  = '{8'h07, 8'h01, 1'b0, 8'h08, 8'h08, 4'b0000};
        tbl[9]  = '{8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 4'b0000};
        tbl[10] = '{8'hFE, 8'h7E, 1'b1, 8'hFE, 8'h7F, 4'b0101};
        tbl[11] = '{8'h3F, 8'h18, 1'b0, 8'h40, 8'h40, 4'b0001};
        tbl[12] = '{8'h40, 8'h3F, 1'b1, 8'h20, 8'h20, 4'b0000};

        rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
        a = '0; b = '0; acc = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", sum, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            clear_flags();
            in_valid = 1'b1; out_ready = 1'b1; sub = tbl[i].s;
            a = {4{tbl[i].a}}; b = {4{tbl[i].b}};
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_sum_sat", i), sum, {4{tbl[i].e_sat}});
            chk($sformatf("vec%0d_sum_nosat", i), ns_sum, {4{tbl[i].e_ns}});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(tbl[i].fl));
            chk($sformatf("vec%0d_flags_nosat", i), 32'(ns_flags), 32'(tbl[i].fl));
        end

        clear_flags();
        base_out = n_out;
        cyc = 0;
        while (n_in < 8 && cyc < 100) begin
            step(1'b1, $urandom(), $urandom(), 1'($urandom()), (cyc % 2) == 0);
            cyc++;
        end
        while (q1.size() > 0 && cyc < 200) begin
            step(1'b0, '0, '0, 1'b0, (cyc % 2) == 0);
            cyc++;
        end
        chk("bp_out_count", 32'(n_out - base_out), 32'd8);
        chk("bp_flags", 32'(flags), 32'(acc));

        clear_flags();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(), 1'($urandom()),
                 1'($urandom_range(0, 2) != 0));
        end
        cyc = 0;
        while (q1.size() > 0 && cyc < 50) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            cyc++;
        end
        chk("rand_count", 32'(n_out), 32'(n_in));
        chk("rand_flags", 32'(flags), 32'(acc));
        chk("rand_flags_nosat", 32'(ns_flags), 32'(acc));

        step(1'b1, 32'h38383838, 32'h39393939, 1'b0, 1'b0);
        step(1'b1, 32'h39183918, 32'h18391839, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q1.delete(); q0.delete(); qf.delete();
        held_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_partial", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
